// File: rtl/obstacle_spawner.sv
// obstacle_spawner
// Spawns obstacles at the right screen edge at a level-dependent rate,
// scrolls them left on every frame_tick, retires them at the left edge
// (counting each one cleared), and raises a one-cycle hit pulse when any
// obstacle overlaps the fixed-x player. A hit clears the whole field.
module obstacle_spawner #(
  parameter int NUM_OBS  = 4,
  parameter int SCREEN_W = 640,
  parameter int Y_MAX    = 464,
  parameter int OBS_W    = 16,
  parameter int OBS_H    = 16,
  parameter int PLAYER_X = 64,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16,
  parameter int GAP_L0   = 120,
  parameter int GAP_L1   = 60,
  parameter int GAP_L2   = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   lvl0,
  input  logic                   lvl1,
  input  logic [9:0]             player_y,
  output logic [NUM_OBS-1:0]     obs_valid,
  output logic [11*NUM_OBS-1:0]  obs_x,
  output logic [10*NUM_OBS-1:0]  obs_y,
  output logic                   hit,
  output logic [10:0]            obj_count
);

  localparam int CW = 16;
  localparam logic [CW-1:0] GAP0_C      = CW'(GAP_L0);
  localparam logic [CW-1:0] GAP1_C      = CW'(GAP_L1);
  localparam logic [CW-1:0] GAP2_C      = CW'(GAP_L2);
  localparam logic [CW-1:0] CNT_ZERO_C  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
  localparam logic [10:0]   SPAWN_X_C   = 11'(SCREEN_W);
  localparam logic [9:0]    Y_MAX_C     = 10'(Y_MAX);
  localparam logic [11:0]   PX_LO_C     = 12'(PLAYER_X);
  localparam logic [11:0]   PX_HI_C     = 12'(PLAYER_X + PLAYER_W);
  localparam logic [11:0]   OBS_W_C     = 12'(OBS_W);
  localparam logic [11:0]   OBS_H_C     = 12'(OBS_H);
  localparam logic [11:0]   PLAYER_H_C  = 12'(PLAYER_H);
  localparam logic [10:0]   COUNT_MAX_C = 11'h7FF;
  localparam logic [9:0]    LFSR_SEED_C = 10'h001;
  localparam logic [NUM_OBS-1:0] SLOT_ONE_C = NUM_OBS'(1);

  // Registered state
  logic [NUM_OBS-1:0] valid_q, valid_d;
  logic [10:0]        x_q [NUM_OBS];
  logic [10:0]        x_d [NUM_OBS];
  logic [9:0]         y_q [NUM_OBS];
  logic [9:0]         y_d [NUM_OBS];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [9:0]         lfsr_q, lfsr_d;
  logic               hit_q, hit_d;
  logic               armed_q, armed_d;
  logic [10:0]        count_q, count_d;

  // Combinational helpers
  logic [1:0]         speed_s;
  logic [CW-1:0]      gap_s;
  logic [9:0]         spawn_y_s;
  logic [NUM_OBS-1:0] overlap_s;
  logic               any_overlap_s;
  logic [NUM_OBS-1:0] spawn_sel_s;
  logic [3:0]         retire_n_s;
  logic [11:0]        count_sum_s;

  // Fibonacci LFSR, taps 10 and 7; never reaches zero from a non-zero seed
  assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  // Lowest slot that is free before this tick's retirements (one-hot, zero if full)
  assign spawn_sel_s = ~valid_q & (valid_q + SLOT_ONE_C);

  // Level decode: lvl0 has priority over lvl1
  always_comb begin
    if (lvl0) begin
      speed_s = 2'd1;
      gap_s   = GAP0_C;
    end else if (lvl1) begin
      speed_s = 2'd2;
      gap_s   = GAP1_C;
    end else begin
      speed_s = 2'd3;
      gap_s   = GAP2_C;
    end
  end

  // Fold the 9 low LFSR bits into the legal y range
  always_comb begin
    if ({1'b0, lfsr_q[8:0]} < Y_MAX_C) begin
      spawn_y_s = {1'b0, lfsr_q[8:0]};
    end else begin
      spawn_y_s = {1'b0, lfsr_q[8:0]} - Y_MAX_C;
    end
  end

  // Per-slot rectangle overlap against the player, 12-bit so sums never wrap
  always_comb begin
    overlap_s = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      overlap_s[i] = valid_q[i]
                   && ({1'b0, x_q[i]} < PX_HI_C)
                   && (({1'b0, x_q[i]} + OBS_W_C) > PX_LO_C)
                   && ({2'b00, y_q[i]} < ({2'b00, player_y} + PLAYER_H_C))
                   && (({2'b00, y_q[i]} + OBS_H_C) > {2'b00, player_y});
    end
    any_overlap_s = |overlap_s;
  end

  // Hit pulses once per overlap episode; re-arms on the first clear cycle
  always_comb begin
    hit_d = any_overlap_s & armed_q;
    if (hit_d) begin
      armed_d = 1'b0;
    end else if (!any_overlap_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Field update: hit clear wins over a coincident tick; otherwise scroll/retire/spawn
  always_comb begin
    valid_d     = valid_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    retire_n_s  = 4'd0;
    count_sum_s = {1'b0, count_q};
    if (hit_q) begin
      valid_d = '0;
      count_d = 11'd0;
      cnt_d   = GAP0_C;
    end else if (frame_tick) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (valid_q[i]) begin
          if (x_q[i] < {9'd0, speed_s}) begin
            valid_d[i] = 1'b0;
            retire_n_s = retire_n_s + 4'd1;
          end else begin
            x_d[i] = x_q[i] - {9'd0, speed_s};
          end
        end else begin
          x_d[i] = x_q[i];
        end
      end
      count_sum_s = {1'b0, count_q} + {8'd0, retire_n_s};
      if (count_sum_s > {1'b0, COUNT_MAX_C}) begin
        count_d = COUNT_MAX_C;
      end else begin
        count_d = count_sum_s[10:0];
      end
      if (cnt_q != CNT_ZERO_C) begin
        cnt_d = cnt_q - CNT_ONE_C;
      end else if (spawn_sel_s != '0) begin
        for (int i = 0; i < NUM_OBS; i++) begin
          if (spawn_sel_s[i]) begin
            valid_d[i] = 1'b1;
            x_d[i]     = SPAWN_X_C;
            y_d[i]     = spawn_y_s;
          end else begin
            valid_d[i] = valid_d[i];
          end
        end
        cnt_d = gap_s;
      end else begin
        cnt_d = CNT_ZERO_C;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_OBS; i++) begin
        x_q[i] <= 11'd0;
        y_q[i] <= 10'd0;
      end
      cnt_q   <= GAP0_C;
      lfsr_q  <= LFSR_SEED_C;
      hit_q   <= 1'b0;
      armed_q <= 1'b1;
      count_q <= 11'd0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NUM_OBS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      hit_q   <= hit_d;
      armed_q <= armed_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
    assign obs_x[11*g +: 11] = x_q[g];
    assign obs_y[10*g +: 10] = y_q[g];
  end

  assign obs_valid = valid_q;
  assign hit       = hit_q;
  assign obj_count = count_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner
// Reference model + scoreboard checks every cycle; a table of hand-computed
// checkpoints and directed sequences cover spawn timing, retirement, slot
// exhaustion, collision/clear and asynchronous reset.
module tb_obstacle_spawner;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic          lvl0;
  logic          lvl1;
  logic [9:0]    player_y;
  logic [N-1:0]  obs_valid;
  logic [11*N-1:0] obs_x;
  logic [10*N-1:0] obs_y;
  logic          hit;
  logic [10:0]   obj_count;

  always #5 clk = ~clk;

  obstacle_spawner dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .lvl0       (lvl0),
    .lvl1       (lvl1),
    .player_y   (player_y),
    .obs_valid  (obs_valid),
    .obs_x      (obs_x),
    .obs_y      (obs_y),
    .hit        (hit),
    .obj_count  (obj_count)
  );

  typedef struct {
    logic [N-1:0]    v;
    logic [11*N-1:0] x;
    logic [10*N-1:0] y;
    logic            h;
    logic [10:0]     c;
  } exp_t;

  typedef struct {
    int   upto;
    bit   l0;
    bit   l1;
    logic [3:0] v;
    int   x0;
    int   c;
  } row_t;

  exp_t sb_q[$];
  row_t tbl[10];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ticks = 0;

  // Reference model state
  logic [N-1:0] m_v;
  logic [10:0]  m_x [N];
  logic [9:0]   m_y [N];
  int           m_cnt;
  logic [9:0]   m_lfsr;
  bit           m_hit;
  bit           m_armed;
  int           m_count;

  task automatic model_reset();
    m_v = '0;
    for (int i = 0; i < N; i++) begin
      m_x[i] = 11'd0;
      m_y[i] = 10'd0;
    end
    m_cnt   = 120;
    m_lfsr  = 10'h001;
    m_hit   = 1'b0;
    m_armed = 1'b1;
    m_count = 0;
  endtask

  function automatic bit model_overlap();
    bit r;
    r = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && int'(m_x[i]) < 80 && int'(m_x[i]) + 16 > 64 &&
          int'(m_y[i]) < int'(player_y) + 16 && int'(m_y[i]) + 16 > int'(player_y))
        r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step();
    bit ov, nhit, narm;
    int spd, gap, ret, fidx, ncnt, ncount;
    logic [N-1:0] nv;
    logic [10:0]  nx [N];
    logic [9:0]   ny [N];
    logic [9:0]   sy;
    ov   = model_overlap();
    nhit = ov && m_armed;
    narm = nhit ? 1'b0 : (ov ? m_armed : 1'b1);
    nv = m_v; nx = m_x; ny = m_y; ncnt = m_cnt; ncount = m_count;
    if (m_lfsr[8:0] < 9'd464) sy = {1'b0, m_lfsr[8:0]};
    else                       sy = {1'b0, m_lfsr[8:0]} - 10'd464;
    if (m_hit) begin
      nv = '0; ncount = 0; ncnt = 120;
    end else if (frame_tick) begin
      if (lvl0)      begin spd = 1; gap = 120; end
      else if (lvl1) begin spd = 2; gap = 60;  end
      else           begin spd = 3; gap = 30;  end
      fidx = -1;
      for (int i = 0; i < N; i++) if (!m_v[i] && fidx < 0) fidx = i;
      ret = 0;
      for (int i = 0; i < N; i++) begin
        if (m_v[i]) begin
          if (int'(m_x[i]) < spd) begin nv[i] = 1'b0; ret++; end
          else nx[i] = 11'(int'(m_x[i]) - spd);
        end
      end
      ncount = m_count + ret;
      if (ncount > 2047) ncount = 2047;
      if (m_cnt > 0) ncnt = m_cnt - 1;
      else if (fidx >= 0) begin
        nv[fidx] = 1'b1; nx[fidx] = 11'd640; ny[fidx] = sy; ncnt = gap;
      end
    end
    m_lfsr  = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    m_v = nv; m_x = nx; m_y = ny; m_cnt = ncnt; m_count = ncount;
    m_hit = nhit; m_armed = narm;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, predict, then compare after the edge
  task automatic step(input logic ft);
    exp_t e, g;
    bit bad;
    @(negedge clk);
    frame_tick = ft;
    model_step();
    e.v = m_v; e.h = m_hit; e.c = 11'(m_count);
    for (int i = 0; i < N; i++) begin
      e.x[11*i +: 11] = m_x[i];
      e.y[10*i +: 10] = m_y[i];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    bad = (obs_valid !== g.v) || (hit !== g.h) || (obj_count !== g.c);
    for (int i = 0; i < N; i++) begin
      if (g.v[i] && (obs_x[11*i +: 11] !== g.x[11*i +: 11] || obs_y[10*i +: 10] !== g.y[10*i +: 10]))
        bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL scoreboard t=%0t valid %b/%b hit %b/%b count %0d/%0d x %h/%h y %h/%h (got/expected)",
               $time, obs_valid, g.v, hit, g.h, obj_count, g.c, obs_x, g.x, obs_y, g.y);
    end
  endtask

  task automatic tick();
    step(1'b1);
    step(1'b0);
    ticks++;
  endtask

  initial begin
    bit found;
    reset = 1'b1; frame_tick = 1'b0; lvl0 = 1'b1; lvl1 = 1'b0; player_y = 10'd500;

    // cumulative tick count, levels, expected valid mask, slot-0 x, obj_count
    tbl[0] = '{upto:120, l0:1'b1, l1:1'b0, v:4'b0000, x0:0,   c:0};
    tbl[1] = '{upto:121, l0:1'b1, l1:1'b0, v:4'b0001, x0:640, c:0};
    tbl[2] = '{upto:122, l0:1'b1, l1:1'b0, v:4'b0001, x0:639, c:0};
    tbl[3] = '{upto:363, l0:1'b1, l1:1'b0, v:4'b0111, x0:398, c:0};
    tbl[4] = '{upto:604, l0:1'b1, l1:1'b0, v:4'b1111, x0:157, c:0};
    tbl[5] = '{upto:756, l0:1'b1, l1:1'b0, v:4'b1111, x0:5,   c:0};
    tbl[6] = '{upto:757, l0:1'b0, l1:1'b1, v:4'b1111, x0:3,   c:0};
    tbl[7] = '{upto:758, l0:1'b0, l1:1'b1, v:4'b1111, x0:1,   c:0};
    tbl[8] = '{upto:759, l0:1'b0, l1:1'b1, v:4'b1110, x0:0,   c:1};
    tbl[9] = '{upto:760, l0:1'b0, l1:1'b1, v:4'b1111, x0:640, c:1};

    model_reset();
    #12;
    chk("reset_valid", 64'(obs_valid), 64'(0));
    chk("reset_x",     64'(obs_x),     64'(0));
    chk("reset_y",     64'(obs_y),     64'(0));
    chk("reset_hit",   64'(hit),       64'(0));
    chk("reset_count", 64'(obj_count), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Spawn timing, scrolling, slot exhaustion, retirement, deferred spawn
    for (int k = 0; k < 10; k++) begin
      lvl0 = tbl[k].l0;
      lvl1 = tbl[k].l1;
      while (ticks < tbl[k].upto) tick();
      chk($sformatf("tbl%0d_valid", k), 64'(obs_valid), 64'(tbl[k].v));
      if (tbl[k].v[0]) chk($sformatf("tbl%0d_x0", k), 64'(obs_x[10:0]), 64'(tbl[k].x0));
      chk($sformatf("tbl%0d_count", k), 64'(obj_count), 64'(tbl[k].c));
    end

    // Collision: put the player on slot 1's row and scroll it into range
    player_y = m_y[1];
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1'b1);
      if (model_overlap()) found = 1'b1;
      else step(1'b0);
    end
    if (!found) begin
      n_vec++; n_bad++;
      $display("FAIL collision_timeout: got no overlap expected overlap within 40 ticks");
    end
    chk("hit_latency", 64'(hit), 64'(0));
    step(1'b0);
    chk("hit_pulse", 64'(hit), 64'(1));
    step(1'b1);   // frame_tick coincident with hit: dropped
    player_y = 10'd500;
    chk("hit_clear_valid", 64'(obs_valid), 64'(0));
    chk("hit_clear_count", 64'(obj_count), 64'(0));
    chk("hit_single",      64'(hit),       64'(0));
    for (int k = 0; k < 120; k++) tick();
    chk("post_hit_gap_valid", 64'(obs_valid), 64'(0));
    tick();
    chk("post_hit_spawn_valid", 64'(obs_valid), 64'(4'b0001));
    chk("post_hit_spawn_x",     64'(obs_x[10:0]), 64'(640));

    // Asynchronous reset with three slots occupied
    for (int k = 0; k < 300 && $countones(m_v) != 3; k++) tick();
    chk("pre_reset_three", 64'($countones(obs_valid)), 64'(3));
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 64'(obs_valid), 64'(0));
    chk("async_x",     64'(obs_x),     64'(0));
    chk("async_y",     64'(obs_y),     64'(0));
    chk("async_hit",   64'(hit),       64'(0));
    chk("async_count", 64'(obj_count), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lvl0 = 1'b1; lvl1 = 1'b0;
    for (int k = 0; k < 120; k++) tick();
    chk("rst_gap_valid", 64'(obs_valid), 64'(0));
    tick();
    chk("rst_spawn_valid",  64'(obs_valid), 64'(4'b0001));
    chk("rst_spawn_y_lfsr", 64'(obs_y[9:0]), 64'(m_y[0]));
    chk("rst_spawn_y_range", 64'(obs_y[9:0] < 10'd464), 64'(1));

    // Level 2+ speed/gap, then both level bits set (lvl0 wins)
    lvl0 = 1'b0; lvl1 = 1'b0;
    for (int k = 0; k < 150; k++) tick();
    lvl0 = 1'b1; lvl1 = 1'b1;
    for (int k = 0; k < 20; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
